// File: rtl/de3d_tc_mc_we_n_if.sv
// rtl/de3d_tc_mc_we_n_if.sv - texture cache line-fill write-enable bus
// Purpose: groups the burst control, push and RAM write signals between the
//    memory controller (master) and the bank write-enable generator (slave).
// Ports (slave view):
//    burst_start, ram_sel, burst_len, line_idx, tex_push_en : inputs
//    ram_wen, ram_waddr, busy, burst_done, push_err         : outputs
interface de3d_tc_mc_we_n_if #(
   parameter int NUM_BANKS = 4,
   parameter int LEN_W     = 6,
   parameter int LINE_W    = 5
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = LEN_W - BANK_W;

   logic                    burst_start;
   logic [BANK_W-1:0]       ram_sel;
   logic [LEN_W-1:0]        burst_len;
   logic [LINE_W-1:0]       line_idx;
   logic                    tex_push_en;
   logic [NUM_BANKS-1:0]    ram_wen;
   logic [LINE_W+ROW_W-1:0] ram_waddr;
   logic                    busy;
   logic                    burst_done;
   logic                    push_err;

   modport master (
      output burst_start, ram_sel, burst_len, line_idx, tex_push_en,
      input  ram_wen, ram_waddr, busy, burst_done, push_err
   );

   modport slave (
      input  burst_start, ram_sel, burst_len, line_idx, tex_push_en,
      output ram_wen, ram_waddr, busy, burst_done, push_err
   );
endinterface

// File: rtl/de3d_tc_mc_we_n.sv
// rtl/de3d_tc_mc_we_n.sv - texture RAM bank write-enable generator for line fills
// Purpose: spreads a burst of pushed data words across NUM_BANKS texture RAM
//    banks in rotation, producing a one-hot bank write enable and a bank-local
//    address {line, row} for every accepted push.
// Ports:
//    mclock : memory controller clock, rising edge
//    rstn   : asynchronous active-low reset
//    bus    : slave side of de3d_tc_mc_we_n_if (burst control in, RAM writes out)
module de3d_tc_mc_we_n #(
   parameter int NUM_BANKS = 4,
   parameter int LEN_W     = 6,
   parameter int LINE_W    = 5
) (
   input  logic               mclock,
   input  logic               rstn,
   de3d_tc_mc_we_n_if.slave   bus
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state;
   logic [BANK_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LINE_W-1:0] line_q;
   logic              burst_done_q;
   logic              push_err_q;

   logic              push_ok;
   logic              last_word;
   logic [BANK_W-1:0] bank;
   logic [LEN_W-1:0]  len_m1;

   // A burst_start wins over a coincident push; that push is dropped.
   assign push_ok   = bus.tex_push_en & (state == FILL) & ~bus.burst_start;

   // NUM_BANKS is a power of two, so the BANK_W-bit sum wraps naturally.
   assign bank      = base_q + cnt_q[BANK_W-1:0];

   // len_q == 0 encodes a full 2^LEN_W burst; the wrapping subtract covers it.
   assign len_m1    = len_q - CNT_ONE;
   assign last_word = (cnt_q == len_m1);

   always_comb begin
      bus.ram_wen = '0;
      if (push_ok)
         bus.ram_wen[bank] = 1'b1;
   end

   assign bus.ram_waddr  = {line_q, cnt_q[LEN_W-1:BANK_W]};
   assign bus.busy       = (state == FILL);
   assign bus.burst_done = burst_done_q;
   assign bus.push_err   = push_err_q;

   always_ff @(posedge mclock or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         base_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         line_q       <= '0;
         burst_done_q <= 1'b0;
         push_err_q   <= 1'b0;
      end else begin
         burst_done_q <= 1'b0;
         push_err_q   <= bus.tex_push_en & ~push_ok;
         if (bus.burst_start) begin
            // Restarts from any state; an aborted burst never signals done.
            base_q <= bus.ram_sel;
            len_q  <= bus.burst_len;
            line_q <= bus.line_idx;
            cnt_q  <= '0;
            state  <= FILL;
         end else if (push_ok) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (last_word) begin
               state        <= IDLE;
               burst_done_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/de3d_tc_mc_we_n.md
DE3D_TC_MC_WE_N -- requirements
Module: de3d_tc_mc_we_n

Interface
REQ-001 Parameter: NUM_BANKS, default 4, number of texture RAM banks written in rotation; power of two, 2..8.
REQ-002 Parameter: LEN_W, default 6, width of the burst length and word counter; LEN_W > log2(NUM_BANKS).
REQ-003 Parameter: LINE_W, default 5, width of the cache line index.
REQ-004 Local: BANK_W = log2(NUM_BANKS); ROW_W = LEN_W - BANK_W.
REQ-005 mclock  in  1  memory controller clock; all state changes on the rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset; one clock, no other reset.
REQ-007 burst_start  in  1  single-cycle pulse that begins a line fill.
REQ-008 ram_sel  in  BANK_W  first bank of the burst; sampled on burst_start.
REQ-009 burst_len  in  LEN_W  words in the burst; 0 encodes 2^LEN_W; sampled on burst_start.
REQ-010 line_idx  in  LINE_W  cache line being filled; sampled on burst_start.
REQ-011 tex_push_en  in  1  memory controller push enable; one data word per asserted cycle.
REQ-012 ram_wen  out  NUM_BANKS  one-hot per-bank write enable; combinational, same cycle as the push.
REQ-013 ram_waddr  out  LINE_W+ROW_W  bank-local write address {line_q, row}; combinational.
REQ-014 busy  out  1  registered; high while in FILL.
REQ-015 burst_done  out  1  registered single-cycle pulse after the last word is written.
REQ-016 push_err  out  1  registered single-cycle pulse flagging a dropped push.

Function
REQ-017 The FSM SHALL have two states, IDLE and FILL; busy = (state == FILL).
REQ-018 On burst_start in any state: the block SHALL load base_q=ram_sel, len_q=burst_len, line_q=line_idx and cnt_q=0, then enter FILL on the next edge. A burst_start in FILL aborts the current burst with no burst_done.
REQ-019 An accepted push SHALL be tex_push_en & (state==FILL) & ~burst_start.
REQ-020 On an accepted push: ram_wen SHALL equal onehot((base_q + cnt_q[BANK_W-1:0]) mod NUM_BANKS), and ram_waddr SHALL equal {line_q, cnt_q[LEN_W-1:BANK_W]}. In all other cycles ram_wen SHALL be all zeros.
REQ-021 Each accepted push SHALL increment cnt_q by 1, modulo 2^LEN_W.
REQ-022 Last word: when an accepted push occurs with cnt_q == len_q-1 (mod 2^LEN_W, so len_q=0 means cnt_q = 2^LEN_W-1), the block SHALL return to IDLE and pulse burst_done on the next cycle.
REQ-023 A tex_push_en in IDLE, or coincident with burst_start, SHALL be dropped: no ram_wen, no counter change, and push_err pulses on the next cycle.
REQ-024 Non-contiguous pushes (gaps between pushes) SHALL be legal; state holds across gaps.
REQ-025 Bank rotation SHALL wrap modulo NUM_BANKS with no other wrap logic, so any ram_sel and any burst_len are valid.
REQ-026 At most one bit of ram_wen SHALL be high in any cycle.

Reset
REQ-027 While rstn is low: state=IDLE; cnt_q, base_q, len_q and line_q are 0; busy, burst_done and push_err are 0. ram_wen is 0 because state is IDLE.
REQ-028 Asserting rstn mid-burst SHALL abandon the burst immediately with no burst_done. The first cycle after release behaves as IDLE.

Verification
REQ-029 NUM_BANKS=4: burst_start with ram_sel=2, burst_len=8, line_idx=3, then 8 back-to-back pushes -> ram_wen = 4,8,1,2,4,8,1,2; ram_waddr = {3,0}x4 then {3,1}x4; burst_done is high for exactly one cycle after the 8th push; busy drops with it.
REQ-030 NUM_BANKS=2: ram_sel=1, burst_len=3, with pushes on cycles 1, 3 and 6 -> ram_wen = 2,1,2 only in those cycles; burst_done follows the third push.
REQ-031 Push in IDLE, and push coincident with burst_start -> ram_wen stays 0 and push_err pulses once for each.
REQ-032 burst_len=0 with LEN_W=6 -> 64 pushes are accepted and burst_done follows the 64th; the 65th push produces push_err.
REQ-033 rstn asserted after 5 of 8 words -> outputs are 0 immediately; after release a push gives push_err; a new burst_start restarts from cnt 0.
REQ-034 burst_start mid-burst (after word 2 of 8, new ram_sel=0) -> no burst_done for the old burst; the next push drives ram_wen=1 with row 0.
